// File: rtl/payment_change_unit_if.sv
// Handshake bundle between the checkout controller and the payment/change unit.
// The controller side (master) drives price, coins, cancel and dispenser ready.
interface payment_change_unit_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] price;
  logic             coinValid;
  logic [WIDTH-1:0] coinValue;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] paid;
  logic             changeValid;
  logic [WIDTH-1:0] change;
  logic             refund;
  logic             changeReady;
  logic             done;
  logic             overflow;

  modport master (
    output start, price, coinValid, coinValue, cancel, changeReady,
    input  busy, paid, changeValid, change, refund, done, overflow
  );

  modport slave (
    input  start, price, coinValid, coinValue, cancel, changeReady,
    output busy, paid, changeValid, change, refund, done, overflow
  );
endinterface

// File: rtl/payment_change_unit.sv
// Accumulates coins against a latched price, then presents change or a full
// refund to the dispenser over valid/ready. All outputs come straight from flops.
module payment_change_unit #(
  parameter int WIDTH          = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  payment_change_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PAYOUT  = 2'd2
  } state_e;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic [WIDTH-1:0] paid_q, paid_d;
  logic [WIDTH-1:0] change_q, change_d;
  logic             refund_q, refund_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] coin_amt;
  logic [WIDTH-1:0] paid_next;
  logic             tmo_hit;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    price_d    = price_q;
    paid_d     = paid_q;
    change_d   = change_q;
    refund_d   = refund_q;
    overflow_d = overflow_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;

    coin_amt  = bus.coinValid ? bus.coinValue : '0;
    sum       = {1'b0, paid_q} + {1'b0, coin_amt};
    paid_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    tmo_hit   = TMO_EN && !bus.coinValid && (tmo_q == TMO_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          price_d    = bus.price;
          paid_d     = '0;
          overflow_d = 1'b0;
          refund_d   = 1'b0;
          tmo_d      = '0;
          state_d    = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        paid_d = paid_next;
        if (sum[WIDTH]) overflow_d = 1'b1;

        if (bus.coinValid)  tmo_d = '0;
        else if (TMO_EN)    tmo_d = tmo_q + TW'(1);

        // Abort paths win over a sale so a coin arriving with cancel is refunded.
        if (bus.cancel || tmo_hit) begin
          change_d = paid_next;
          refund_d = 1'b1;
          state_d  = ST_PAYOUT;
        end else if (paid_next >= price_q) begin
          change_d = paid_next - price_q;
          refund_d = 1'b0;
          state_d  = ST_PAYOUT;
        end
      end

      ST_PAYOUT: begin
        if (bus.changeReady) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      price_q    <= '0;
      paid_q     <= '0;
      change_q   <= '0;
      refund_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      price_q    <= price_d;
      paid_q     <= paid_d;
      change_q   <= change_d;
      refund_q   <= refund_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.changeValid = (state_q == ST_PAYOUT);
  assign bus.paid        = paid_q;
  assign bus.change      = change_q;
  assign bus.refund      = refund_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: doc/payment_change_unit.md
Name: payment_change_unit

Overview:
Sequential, parametrised successor to the combinational money-difference block in the barcode-reader checkout path. After a scanned item's price is loaded, the block accumulates inserted coins and decides between completed sale and refund. It computes the change or refund amount and hands it to the dispenser over a valid/ready handshake. Also covers cancel, inactivity timeout and accumulator saturation, none of which a combinational difference can express.

Parameters:
WIDTH, 5, bit width of price, coin value, paid total and change
TIMEOUT_CYCLES, 1000, cycles without a coin before automatic refund; 0 disables timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: latch price and begin a transaction (honoured only in IDLE)
price  input  WIDTH  item price, sampled on start
coinValid  input  1  coinValue is valid this cycle (one coin per cycle)
coinValue  input  WIDTH  value of inserted coin
cancel  input  1  customer abort, honoured in COLLECT
busy  output  1  high in COLLECT and PAYOUT
paid  output  WIDTH  running paid total
changeValid  output  1  change/refund amount is presented
change  output  WIDTH  amount to dispense
refund  output  1  qualifies change: 1 = full refund, 0 = change after sale
changeReady  input  1  dispenser accepts the amount
done  output  1  one-cycle pulse on handshake completion
overflow  output  1  sticky per transaction: the paid total saturated

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, paid=0, changeValid=0, change=0, refund=0, done=0, overflow=0, internal price register=0, timeout counter=0.
- States: IDLE, COLLECT, PAYOUT (2-bit encoding).
- IDLE:
  - start=1 latches price, clears paid, overflow, refund and the timeout counter, then moves to COLLECT next cycle.
  - coinValid, cancel and changeReady are ignored.
- COLLECT:
  - paidNext = paid + coinValue when coinValid, else paid.
  - The sum is computed at WIDTH+1 bits. If the sum is at least 2^WIDTH, paidNext saturates to 2^WIDTH-1 and overflow is set.
  - Priority order each cycle:
    1. cancel=1, or the timeout counter reaches TIMEOUT_CYCLES-1 with no coin this cycle: go to PAYOUT, change=paidNext, refund=1. A coin arriving with cancel is included in the refund.
    2. Else if paidNext >= price: go to PAYOUT, change=paidNext-price (WIDTH bits, never negative), refund=0.
    3. Else stay in COLLECT.
  - The timeout counter clears on any coin and increments otherwise. It is frozen when TIMEOUT_CYCLES=0.
  - price=0 completes the cycle after start with change equal to any coin inserted that cycle, normally 0.
- PAYOUT:
  - changeValid=1; change and refund are held stable.
  - changeValid is asserted even when change=0, because the dispenser must acknowledge every transaction.
  - When changeValid and changeReady are both high: done=1 for exactly that cycle, next state is IDLE, changeValid drops to 0 next cycle.
  - change and paid keep their values in IDLE until the next start.
  - Coins, cancel and start are ignored in PAYOUT. The coin acceptor is expected to be blocked via busy.
- Latency: a coin or cancel sampled at edge N yields changeValid=1 after edge N. The earliest done comes one cycle later.
- start while busy is ignored; the price register is unchanged.
- Reset during COLLECT or PAYOUT aborts the transaction immediately; no done pulse and no refund are issued.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- WIDTH=5, start with price=12; coins 5, 5, 5 on consecutive cycles, changeReady=1 → paid=15, changeValid one cycle after the third coin, change=3, refund=0, done pulses once, then back to IDLE.
- price=10; coin 4, then cancel together with coin 2 → change=6, refund=1, overflow=0.
- price=20; coins 16 and 16 → paid saturates at 31, overflow=1, change=11, refund=0.
- TIMEOUT_CYCLES=8, price=9; coin 3, then idle → changeValid exactly 8 cycles after the coin, change=3, refund=1.
- price=7; coin 7 with changeReady=0 for 5 cycles → changeValid and change=0 held stable for 5 cycles, start pulses ignored, done only when ready rises.
- price=30; coin 10, assert reset mid-COLLECT → all outputs 0 immediately (asynchronously), no done; a new start with price=5 and coin 5 then completes normally with change=0.
